md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
//  Runs mult/multu/div/divu over a configurable number of cycles.
//  Services mfhi/mflo/mthi/mtlo.
//  Exposes busy so the hazard unit can stall a D-stage md instruction while start|busy is high.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk     in   1      single clock; all state updates on posedge
//  reset   in   1      asynchronous, active-high; clears all state
//  start   in   1      E-stage md instruction valid this cycle (one-cycle pulse per instruction)
//  md_op   in   3      0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi/mflo-select(see sel_hi)
//  sel_hi  in   1      md_out source: 1 HI, 0 LO
//  A       in   WIDTH  forwarded rs value
//  B       in   WIDTH  forwarded rt value
//  busy    out  1      registered; high while an operation is in flight
//  hi      out  WIDTH  current HI register
//  lo      out  WIDTH  current LO register
//  md_out  out  WIDTH  combinational sel_hi ? hi : lo (mfhi/mflo result into E_WD path)
// BEHAVIOUR
//  - Reset (any time, incl. mid-operation): busy=0, cnt=0, hi=0, lo=0, pending results discarded.
//  - Accept rule: an op is accepted at a posedge where start=1 and busy=0. start while busy=1 is ignored.
//    The hazard unit guarantees this never happens; the bench checks it is harmless.
//  - mult/multu/div/divu accepted at edge k:
//    - results are computed from A,B at edge k into pend_hi/pend_lo;
//    - cnt<=LAT (MULT_CYCLES or DIV_CYCLES); busy=1 in exactly cycles k+1..k+LAT;
//    - at edge k+LAT: hi<=pend_hi, lo<=pend_lo, busy<=0.
//  - State machine IDLE -> RUN (cnt decrements each edge) -> IDLE when cnt==1 at an edge.
//    There is no back-to-back overlap: a new start is accepted earliest at edge k+LAT+1.
//  - hi/lo hold their old values throughout RUN; a read in RUN returns the old value (the stall prevents it).
//  - mult:  {hi,lo} = signed A * signed B (2*WIDTH product).
//  - multu: {hi,lo} = unsigned A * unsigned B.
//  - div:   lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
//           Special case A=-2^(W-1), B=-1: lo=A, hi=0.
//  - divu:  unsigned quotient/remainder.
//  - Division by zero (B==0): op still runs LAT busy cycles; hi/lo are left unchanged at completion.
//  - mthi/mtlo accepted at edge k: hi<=A (or lo<=A) at edge k; busy stays 0; zero latency.
//  - md_op 0 or 7 with start: no state change.
//  - md_out is purely combinational from hi/lo/sel_hi; no latency.
// STRUCTURE
//  - Shared include md_defs.vh: MD_NONE..MD_MF opcode localparams; used by CTR for md_op and T_use/stall decode.
//  - Single flat module: registers cnt (clog2(max LAT)+1 bits), busy, hi, lo, pend_hi, pend_lo.
//  - Datapath uses behavioural *, /, % on signed/unsigned casts; no sub-module is needed.
//  - Stall contract for the top level: stop |= D_is_md & (E_start | E_busy).
// TESTING
//  1. mult A=FFFFFFFF B=00000002 -> busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFFE.
//  2. multu same operands -> hi=00000001, lo=FFFFFFFE after exactly 5 busy cycles.
//  3. div A=7 B=FFFFFFFE -> busy 10 cycles; lo=FFFFFFFD, hi=00000001.
//     div A=80000000 B=FFFFFFFF -> lo=80000000, hi=0.
//  4. divu A=FFFFFFFF B=2 -> lo=7FFFFFFF, hi=1; then divu by 0 -> 10 busy cycles, hi/lo unchanged.
//  5. mthi A=12345678, next cycle sel_hi=1 -> md_out=12345678, busy never rises.
//     start asserted while busy -> ignored; hi/lo get the first op's results.
//  6. Assert reset asynchronously at busy cycle 3 of a div -> busy, hi, lo =0 immediately with no clock edge.
//     After release, the next mult completes normally.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   md_op_e    - 3-bit md opcode carried from decode to the E stage
//   md_state_e - two-state sequencer (IDLE / RUN)
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MF    = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic is_long_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request/response bundle for md_unit.
//   start, md_op, sel_hi, A, B : request side (pipeline -> unit)
//   busy, hi, lo, md_out       : response side (unit -> pipeline / hazard unit)
// Modports: master = pipeline side, slave = md_unit side.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  import md_unit_pkg::*;

  logic             start;
  md_op_e           md_op;
  logic             sel_hi;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_out;

  modport master (
    output start, md_op, sel_hi, A, B,
    input  busy, hi, lo, md_out
  );

  modport slave (
    input  start, md_op, sel_hi, A, B,
    output busy, hi, lo, md_out
  );

endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-high clear of all state
//   bus   : md_unit_if.slave (start/md_op/sel_hi/A/B in; busy/hi/lo/md_out out)
// Results are computed from A/B at the accepting edge and parked in pend_*;
// HI/LO are only committed when the latency counter expires, so reads during
// RUN still see the previous values.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] pend_hi_reg, pend_lo_reg;
  logic             pend_we_reg;   // cleared for divide-by-zero so HI/LO are kept

  // Combinational datapath
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   a_s, b_s, quot_s, rem_s;
  logic        [WIDTH-1:0]   b_safe, quot_u, rem_u;
  logic                      b_zero, div_ovf;

  always_comb begin
    prod_s = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) * $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
    prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    b_zero = (bus.B == '0);
    // Most-negative / -1 overflows the quotient; defined as lo=A, hi=0.
    div_ovf = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
    // Keep the divider away from a zero divisor; the result is discarded anyway.
    b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.B;
    a_s    = $signed(bus.A);
    b_s    = $signed(b_safe);
    quot_s = a_s / b_s;
    rem_s  = a_s % b_s;
    if (div_ovf) begin
      quot_s = a_s;
      rem_s  = '0;
    end
    quot_u = bus.A / b_safe;
    rem_u  = bus.A % b_safe;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_we_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_long_op(bus.md_op)) begin
              state_reg   <= ST_RUN;
              busy_reg    <= 1'b1;
              pend_we_reg <= 1'b1;
              case (bus.md_op)
                MD_MULT: begin
                  cnt_reg     <= MULT_LAT;
                  pend_hi_reg <= prod_s[2*WIDTH-1:WIDTH];
                  pend_lo_reg <= prod_s[WIDTH-1:0];
                end
                MD_MULTU: begin
                  cnt_reg     <= MULT_LAT;
                  pend_hi_reg <= prod_u[2*WIDTH-1:WIDTH];
                  pend_lo_reg <= prod_u[WIDTH-1:0];
                end
                MD_DIV: begin
                  cnt_reg     <= DIV_LAT;
                  pend_we_reg <= !b_zero;
                  pend_hi_reg <= rem_s;
                  pend_lo_reg <= quot_s;
                end
                default: begin  // MD_DIVU
                  cnt_reg     <= DIV_LAT;
                  pend_we_reg <= !b_zero;
                  pend_hi_reg <= rem_u;
                  pend_lo_reg <= quot_u;
                end
              endcase
            end else if (bus.md_op == MD_MTHI) begin
              hi_reg <= bus.A;
            end else if (bus.md_op == MD_MTLO) begin
              lo_reg <= bus.A;
            end
          end
        end
        ST_RUN: begin
          // A start arriving here is ignored: the unit accepts nothing while busy.
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            if (pend_we_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.hi     = hi_reg;
  assign bus.lo     = lo_reg;
  assign bus.md_out = bus.sel_hi ? hi_reg : lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + randomized bench for md_unit with a behavioural
// reference model of HI/LO built on 64-bit integer arithmetic.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W     = 32;
  localparam int MLAT  = 5;
  localparam int DLAT  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MLAT), .DIV_CYCLES(DLAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: new HI/LO and latency for an accepted op.
  task automatic model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    longint          sp, sq, sr;
    longint unsigned up;
    lat = 0;
    case (op)
      MD_MULT: begin
        lat = MLAT;
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      MD_MULTU: begin
        lat = MLAT;
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      MD_DIV: begin
        lat = DLAT;
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      MD_DIVU: begin
        lat = DLAT;
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
    bus.sel_hi = 1'b1; #1;
    chk({tag, "_mdout_hi"}, bus.md_out, m_hi);
    bus.sel_hi = 1'b0; #1;
    chk({tag, "_mdout_lo"}, bus.md_out, m_lo);
  endtask

  // Issue one op at a negedge, follow it through its busy window, check result.
  task automatic run_op(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] old_hi, old_lo;
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    old_hi = m_hi; old_lo = m_lo;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = MD_NONE;
    model(op, a, b, lat);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_hold_hi"}, bus.hi, old_hi);
      chk({tag, "_hold_lo"}, bus.lo, old_lo);
      @(negedge clk);
    end
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    chk_regs(tag);
    $display("op=%0d A=%h B=%h lat=%0d hi=%h lo=%h [%s]", op, a, b, lat, bus.hi, bus.lo, tag);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    md_op_e rop;
    bus.start = 1'b0; bus.md_op = MD_NONE; bus.sel_hi = 1'b0; bus.A = '0; bus.B = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk_regs("rst");
    reset = 1'b0;

    // Directed cases with hand-derived constants.
    run_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, "mult");
    chk("mult_k_hi", bus.hi, 32'hFFFFFFFF); chk("mult_k_lo", bus.lo, 32'hFFFFFFFE);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, "multu");
    chk("multu_k_hi", bus.hi, 32'h00000001); chk("multu_k_lo", bus.lo, 32'hFFFFFFFE);
    run_op(MD_DIV, 32'h00000007, 32'hFFFFFFFE, "div");
    chk("div_k_hi", bus.hi, 32'h00000001); chk("div_k_lo", bus.lo, 32'hFFFFFFFD);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    chk("ovf_k_hi", bus.hi, 32'h00000000); chk("ovf_k_lo", bus.lo, 32'h80000000);
    run_op(MD_DIVU, 32'hFFFFFFFF, 32'h00000002, "divu");
    chk("divu_k_hi", bus.hi, 32'h00000001); chk("divu_k_lo", bus.lo, 32'h7FFFFFFF);
    run_op(MD_DIVU, 32'h12345678, 32'h00000000, "divu0");
    chk("divu0_k_hi", bus.hi, 32'h00000001); chk("divu0_k_lo", bus.lo, 32'h7FFFFFFF);
    run_op(MD_MTHI, 32'h12345678, 32'h0, "mthi");
    chk("mthi_k", bus.md_out, 32'h7FFFFFFF);
    bus.sel_hi = 1'b1; #1;
    chk("mthi_mdout", bus.md_out, 32'h12345678);
    bus.sel_hi = 1'b0;
    run_op(MD_MTLO, 32'hCAFEF00D, 32'h0, "mtlo");
    run_op(MD_MF, 32'h11111111, 32'h2, "mf_nop");
    run_op(MD_NONE, 32'h22222222, 32'h3, "none_nop");

    // start while busy: an mthi mid-run must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.A = 32'h00000003; bus.B = 32'hFFFFFFFB;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = MD_NONE;
    model(MD_MULT, 32'h00000003, 32'hFFFFFFFB, lat);
    for (int i = 0; i < MLAT; i++) begin
      chk("ovl_busy", {31'd0, bus.busy}, 32'd1);
      if (i == 1) begin
        bus.start = 1'b1; bus.md_op = MD_MTHI; bus.A = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0; bus.md_op = MD_NONE;
      end
      @(negedge clk);
    end
    chk("ovl_idle", {31'd0, bus.busy}, 32'd0);
    chk_regs("ovl");
    @(negedge clk);
    chk("ovl_no_second", {31'd0, bus.busy}, 32'd0);
    $display("overlap: mult hi=%h lo=%h", bus.hi, bus.lo);

    // Asynchronous reset in busy cycle 3 of a div.
    run_op(MD_MTHI, 32'hA5A5A5A5, 32'h0, "pre_rst_hi");
    run_op(MD_MTLO, 32'h5A5A5A5A, 32'h0, "pre_rst_lo");
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = MD_NONE;
    repeat (2) @(negedge clk);
    chk("arst_pre_busy", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    $display("async reset mid-div: busy=%0b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    reset = 1'b0;
    run_op(MD_MULT, 32'h00010000, 32'h00010000, "post_rst");

    // Randomized ops against the model.
    for (int n = 0; n < 40; n++) begin
      rop = md_op_e'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      run_op(rop, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
